// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants, types and helpers for the I2S transmit/receive slice.
// Build option: I2S_TX_LEFT_JUSTIFIED_EN selects left-justified framing (no one-BCLK delay).
package i2s_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int SLOT_W_DEF = 32;
  localparam int FRAME_BITS = 2 * SLOT_W_DEF;

  typedef enum logic {
    I2S_STD = 1'b0,
    I2S_LJ  = 1'b1
  } i2s_fmt_e;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  localparam i2s_fmt_e TX_FMT = I2S_LJ;
`else
  localparam i2s_fmt_e TX_FMT = I2S_STD;
`endif

  // Width of a counter that spans one stereo frame of 2*slot_w BCLKs.
  function automatic int bit_cnt_w(input int slot_w);
    return $clog2(2 * slot_w);
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample-pair handshake between an upstream source and the I2S transmitter.
// The source (master) presents a stereo pair with a one-cycle strobe; the transmitter
// (slave) reports frame requests and under/overrun pulses.
interface i2s_tx_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] iLdata;
  logic [DATA_W-1:0] iRdata;
  logic              iStrobe;
  logic              oFrameReq;
  logic              oUnderrun;
  logic              oOverrun;

  modport master (
    output iLdata, iRdata, iStrobe,
    input  oFrameReq, oUnderrun, oOverrun
  );

  modport slave (
    input  iLdata, iRdata, iStrobe,
    output oFrameReq, oUnderrun, oOverrun
  );

endinterface

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: BCLK divider plus frame bit counter for an I2S master.
// bclk toggles every CLK_DIV clk cycles; bit_cnt advances on each BCLK fall and
// wraps once per stereo frame. fall/rise/frame_start are single-cycle strobes that
// are high in the clk cycle whose closing edge performs the corresponding change.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter  int CLK_DIV = 8,
  parameter  int SLOT_W  = SLOT_W_DEF,
  localparam int CNT_W   = bit_cnt_w(SLOT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             bclk,
  output logic             lrclk,
  output logic             fall,
  output logic             rise,
  output logic             frame_start,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] SLOT_R0  = CNT_W'(SLOT_W);

  logic [DIV_W-1:0] div_cnt_r;
  logic             bclk_r;
  logic             lrclk_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [CNT_W-1:0] bit_cnt_nxt_s;
  logic             wrap_s;
  logic             fall_s;
  logic             rise_s;
  logic             frame_start_s;

  // Divider wrap, BCLK edge strobes and the next bit position.
  always_comb begin
    wrap_s        = (div_cnt_r == DIV_LAST);
    fall_s        = wrap_s & bclk_r;
    rise_s        = wrap_s & ~bclk_r;
    frame_start_s = fall_s & (bit_cnt_r == CNT_LAST);
    if (bit_cnt_r == CNT_LAST) begin
      bit_cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
    end
  end

  // Divider, BCLK toggle, bit counter and word select; lrclk moves only on BCLK falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bclk_r    <= 1'b0;
      lrclk_r   <= 1'b0;
      bit_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (wrap_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
        bclk_r    <= ~bclk_r;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
      if (fall_s) begin
        bit_cnt_r <= bit_cnt_nxt_s;
        lrclk_r   <= (bit_cnt_nxt_s >= SLOT_R0);
      end
    end
  end

  assign bclk        = bclk_r;
  assign lrclk       = lrclk_r;
  assign fall        = fall_s;
  assign rise        = rise_s;
  assign frame_start = frame_start_s;
  assign bit_cnt     = bit_cnt_r;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter. Buffers one pending stereo pair, loads it at each
// frame boundary and shifts it out MSB first on audio_sdata, which changes only on
// BCLK falling edges. Flags underrun (frame loaded without a fresh pair) and overrun
// (a second pair strobed before the first was consumed).
// Build option: I2S_TX_LEFT_JUSTIFIED_EN selects left-justified framing; default is
// standard I2S with the MSB one BCLK after the word-select change.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SLOT_W  = SLOT_W_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  i2s_tx_if.slave smp,
  output logic   audio_bclk,
  output logic   audio_lrclk,
  output logic   audio_sdata
);

  localparam int               CNT_W   = bit_cnt_w(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] SLOT_R0  = CNT_W'(SLOT_W);
  // Slot index of data bit 0 is DATA_W (standard) or DATA_W-1 (left-justified).
  localparam int               FMT_OFS = (TX_FMT == I2S_LJ) ? 1 : 0;

  logic              bclk_s;
  logic              lrclk_s;
  logic              fall_s;
  logic              bclk_rise_s;
  logic              frame_start_s;
  logic [CNT_W-1:0]  bit_cnt_s;

  logic [DATA_W-1:0] hold_left_r;
  logic [DATA_W-1:0] hold_right_r;
  logic [DATA_W-1:0] act_left_r;
  logic [DATA_W-1:0] act_right_r;
  logic              fresh_r;
  logic              frame_req_r;
  logic              underrun_r;
  logic              overrun_r;
  logic              sdata_r;

  logic [DATA_W-1:0] act_left_nxt_s;
  logic [DATA_W-1:0] act_right_nxt_s;
  logic [DATA_W-1:0] ch_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [CNT_W-1:0]  slot_s;
  logic              lr_nxt_s;
  logic              sdata_nxt_s;

  i2s_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .SLOT_W  (SLOT_W)
  ) u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .bclk        (bclk_s),
    .lrclk       (lrclk_s),
    .fall        (fall_s),
    .rise        (bclk_rise_s),
    .frame_start (frame_start_s),
    .bit_cnt     (bit_cnt_s)
  );

  // Next active pair, next bit position and the data bit to drive after this BCLK fall.
  always_comb begin
    if (frame_start_s && smp.iStrobe) begin
      act_left_nxt_s  = smp.iLdata;
      act_right_nxt_s = smp.iRdata;
    end else if (frame_start_s && fresh_r) begin
      act_left_nxt_s  = hold_left_r;
      act_right_nxt_s = hold_right_r;
    end else begin
      act_left_nxt_s  = act_left_r;
      act_right_nxt_s = act_right_r;
    end

    if (bit_cnt_s == CNT_LAST) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = bit_cnt_s + CNT_W'(1);
    end
    lr_nxt_s = (cnt_nxt_s >= SLOT_R0);
    if (lr_nxt_s) begin
      slot_s = cnt_nxt_s - SLOT_R0;
      ch_s   = act_right_nxt_s;
    end else begin
      slot_s = cnt_nxt_s;
      ch_s   = act_left_nxt_s;
    end

    sdata_nxt_s = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      sdata_nxt_s = sdata_nxt_s | (ch_s[i] & (slot_s == CNT_W'(DATA_W - i - FMT_OFS)));
    end
  end

  // Holding/active registers, fresh tracking and handshake pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_left_r  <= {DATA_W{1'b0}};
      hold_right_r <= {DATA_W{1'b0}};
      act_left_r   <= {DATA_W{1'b0}};
      act_right_r  <= {DATA_W{1'b0}};
      fresh_r      <= 1'b0;
      frame_req_r  <= 1'b0;
      underrun_r   <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      act_left_r  <= act_left_nxt_s;
      act_right_r <= act_right_nxt_s;
      if (smp.iStrobe) begin
        hold_left_r  <= smp.iLdata;
        hold_right_r <= smp.iRdata;
      end
      if (frame_start_s) begin
        // A strobe on the load cycle bypasses into the active pair, so nothing stays pending.
        fresh_r     <= 1'b0;
        frame_req_r <= 1'b1;
        underrun_r  <= ~(smp.iStrobe | fresh_r);
        overrun_r   <= 1'b0;
      end else begin
        fresh_r     <= fresh_r | smp.iStrobe;
        frame_req_r <= 1'b0;
        underrun_r  <= 1'b0;
        overrun_r   <= smp.iStrobe & fresh_r;
      end
    end
  end

  // Serial data register; updated in step with the BCLK falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdata_r <= 1'b0;
    end else if (fall_s) begin
      sdata_r <= sdata_nxt_s;
    end
  end

  assign audio_bclk    = bclk_s;
  assign audio_lrclk   = lrclk_s;
  assign audio_sdata   = sdata_r;
  assign smp.oFrameReq = frame_req_r;
  assign smp.oUnderrun = underrun_r;
  assign smp.oOverrun  = overrun_r;

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter; the playback-side neighbour of the I2S receive stage.
- Consumes stereo 24-bit sample pairs qualified by a one-cycle strobe, in the same form the receive stage emits (direct loopback possible).
- Generates BCLK/LRCLK from the system clock and serialises samples to the codec DAC pin.
- Buffers one pending pair and flags underrun/overrun.

Parameters:
- CLK_DIV, 8: clk cycles per BCLK half-period; legal range ≥2. BCLK = clk/(2*CLK_DIV); frame = 128*CLK_DIV clk cycles.
- DATA_W, 24: sample width, MSB first.
- SLOT_W, 32: BCLKs per channel slot; SLOT_W ≥ DATA_W+1.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- iLdata  in  DATA_W  left sample, valid when iStrobe=1
- iRdata  in  DATA_W  right sample, valid when iStrobe=1
- iStrobe  in  1  one-cycle pulse; captures the pair into the holding register
- audio_bclk  out  1  bit clock to codec
- audio_lrclk  out  1  word select; 0 = left, 1 = right
- audio_sdata  out  1  serial data; changes only on BCLK falling edge
- oFrameReq  out  1  one-cycle pulse when a frame is loaded; upstream may supply the next pair
- oUnderrun  out  1  one-cycle pulse: frame loaded with no fresh pair
- oOverrun  out  1  one-cycle pulse: iStrobe while a pair is already pending

Behaviour:
- Reset (async assert, sync release): all outputs 0, including bclk, lrclk, sdata and all pulses. div_cnt=0, bit_cnt=0, fresh=0, holding and active registers 0. Mid-frame reset aborts the frame; pending data is discarded.
- Divider: div_cnt counts 0..CLK_DIV-1. At wrap, bclk toggles. A 1→0 toggle is a "fall event"; a 0→1 toggle is a "rise event".
- Bit counter: bit_cnt (log2(2*SLOT_W) bits) increments on each fall event and wraps 2*SLOT_W-1 → 0.
  - lrclk = (bit_cnt ≥ SLOT_W), registered, updated on fall events only.
  - slot s = bit_cnt mod SLOT_W.
- Data, standard I2S (one-BCLK delay):
  - s in 1..DATA_W: sdata = active_ch[DATA_W-s].
  - s = 0 or s > DATA_W: sdata = 0.
  - active_ch is the left register when lrclk=0, the right register otherwise.
- Holding/fresh:
  - iStrobe writes hold_l/hold_r and sets fresh.
  - iStrobe while fresh=1: overwrite the holding registers; oOverrun=1 for that cycle.
- Frame load, on the fall event where bit_cnt wraps to 0:
  - fresh=1: active ← hold; fresh cleared.
  - fresh=0: active unchanged (last pair repeats); oUnderrun=1.
  - oFrameReq=1 in the same cycle in both cases.
- iStrobe coincident with frame load: the strobed pair bypasses straight into active, counts as fresh, and leaves fresh=0. No underrun, no overrun.
- First frame after reset transmits zeros; the first load occurs 2*SLOT_W BCLKs after release. This first load flags underrun unless a strobe has arrived.
- Latency, strobe to MSB on pin: ≤ one frame plus one BCLK.

Optional Feature:
- Macro I2S_TX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format with no one-BCLK delay. s in 0..DATA_W-1: sdata = active_ch[DATA_W-1-s]; else 0.
- Undefined: standard I2S as specified above.
- Clocking, load and flag behaviour are identical in both modes.

Decomposition:
- Package i2s_pkg: DATA_W and SLOT_W defaults, FRAME_BITS = 2*SLOT_W, bit_cnt width function, format enum {I2S_STD, I2S_LJ}.
- Sub-module i2s_clk_gen: divider plus bit counter. Outputs bclk, lrclk, fall/rise event strobes, bit_cnt, and frame_start. The receive side reuses it for master mode.

Test Plan (CLK_DIV=2, SLOT_W=32):
- Reset then idle: bclk period 4 clk, lrclk period 256 clk; sdata stays 0; oUnderrun pulses every 256 clk, coincident with oFrameReq.
- Strobe L=24'hA5F00F, R=24'h123456 once: next frame left slot shows 0 then bits A5F00F MSB-first in slots 1..24, then 0s. Right slot shows 123456. No underrun on that load.
- No further strobe: the following frame repeats A5F00F/123456 and oUnderrun=1.
- Two strobes (111111/222222, then 333333/444444) within one frame: oOverrun=1 on the second; next frame sends 333333/444444.
- Strobe exactly on the frame-load cycle with 0x800001/0x7FFFFF: transmitted in the frame starting that cycle; no underrun, no overrun.
- Assert rst_n low mid right slot: outputs go 0 immediately. After release, the first lrclk rise occurs 32 BCLKs later. With I2S_TX_LEFT_JUSTIFIED_EN defined, MSB appears in slot 0.
